// File: rtl/mul_accumulator.sv
// ----------------------------------------------------------------------------
// mul_accumulator
//   Sums N_TERMS signed 32-bit multiplier products into a saturating ACC_W-bit
//   accumulator and hands each finished sum to a one-deep valid/ready output
//   register. When the output register is still occupied at group end, the
//   finished sum is parked in the accumulator (HOLD) and upstream is stalled.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mul_accumulator #(
  parameter int ACC_W   = 40,
  parameter int N_TERMS = 4
) (
  input  logic             a_clk,
  input  logic             a_rst_n,
  input  logic             a_clr,
  input  logic             a_done,
  input  logic [31:0]      a_prod,
  output logic [ACC_W-1:0] a_out,
  output logic             a_out_valid,
  input  logic             a_out_ready,
  output logic [7:0]       a_count,
  output logic             a_stall,
  output logic             a_sat,
  output logic             a_drop
);

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

  // Saturation limits expressed in ACC_W bits.
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [0:0]       state_q, state_d;
  logic             done_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       count_q, count_d;
  logic [ACC_W-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             sat_q, sat_d;
  logic             drop_q, drop_d;

  logic             term_ev;
  logic             accept;
  logic [ACC_W:0]   sum_wide;
  logic             sum_ovf;
  logic [ACC_W-1:0] sum_sat;

  assign term_ev = a_done & ~done_q;
  assign accept  = out_valid_q & a_out_ready;

  // One guard bit is enough: a 32-bit addend can never push an ACC_W>=33
  // value more than one bit beyond range, so overflow is the top two bits
  // disagreeing, and the guard bit gives the direction.
  assign sum_wide = {acc_q[ACC_W-1], acc_q}
                  + {{(ACC_W+1-32){a_prod[31]}}, a_prod};
  assign sum_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  // Clamp the widened sum back into ACC_W bits.
  always_comb begin
    sum_sat = sum_wide[ACC_W-1:0];
    if (sum_ovf) begin
      sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Next-state logic for the accumulate / hold controller.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    sat_d       = sat_q;
    drop_d      = drop_q;

    // A plain acceptance empties the register; a new result below refills it.
    if (accept) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_ACCUM: begin
        if (term_ev) begin
          if (sum_ovf) begin
            sat_d = 1'b1;
          end
          if (count_q != LAST_CNT) begin
            acc_d   = sum_sat;
            count_d = count_q + 8'd1;
          end else if (!out_valid_q || accept) begin
            out_d       = sum_sat;
            out_valid_d = 1'b1;
            acc_d       = '0;
            count_d     = '0;
          end else begin
            // Output busy: park the finished sum and stall upstream.
            acc_d   = sum_sat;
            state_d = S_HOLD;
          end
        end
      end
      default: begin
        if (term_ev) begin
          drop_d = 1'b1;
        end
        if (accept) begin
          out_d       = acc_q;
          out_valid_d = 1'b1;
          acc_d       = '0;
          count_d     = '0;
          state_d     = S_ACCUM;
        end
      end
    endcase

    // Clear wipes everything except the last result value.
    if (a_clr) begin
      state_d     = S_ACCUM;
      acc_d       = '0;
      count_d     = '0;
      out_d       = out_q;
      out_valid_d = 1'b0;
      sat_d       = 1'b0;
      drop_d      = 1'b0;
    end
  end

  // State registers; done_q keeps sampling through clear so a level-high
  // done at clear does not produce a spurious term.
  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q     <= S_ACCUM;
      done_q      <= 1'b0;
      acc_q       <= '0;
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= a_done;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      drop_q      <= drop_d;
    end
  end

  assign a_out       = out_q;
  assign a_out_valid = out_valid_q;
  assign a_count     = count_q;
  assign a_stall     = (state_q == S_HOLD);
  assign a_sat       = sat_q;
  assign a_drop      = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_accumulator.sv
// ----------------------------------------------------------------------------
// tb_mul_accumulator
//   Directed bench: default instance (ACC_W=40, N_TERMS=4) plus a narrow
//   instance (ACC_W=34, N_TERMS=8) for saturation.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mul_accumulator;

  logic        clk;
  logic        rst_n;

  // Default instance
  logic        clr, done, ready;
  logic [31:0] prod;
  logic [39:0] out;
  logic        out_valid, stall, sat, drop;
  logic [7:0]  count;

  // Saturation instance
  logic        s_clr, s_done, s_ready;
  logic [31:0] s_prod;
  logic [33:0] s_out;
  logic        s_out_valid, s_stall, s_sat, s_drop;
  logic [7:0]  s_count;

  int n_vec = 0;
  int n_err = 0;

  mul_accumulator #(.ACC_W(40), .N_TERMS(4)) u_dut (
    .a_clk(clk), .a_rst_n(rst_n), .a_clr(clr), .a_done(done), .a_prod(prod),
    .a_out(out), .a_out_valid(out_valid), .a_out_ready(ready),
    .a_count(count), .a_stall(stall), .a_sat(sat), .a_drop(drop)
  );

  mul_accumulator #(.ACC_W(34), .N_TERMS(8)) u_sat (
    .a_clk(clk), .a_rst_n(rst_n), .a_clr(s_clr), .a_done(s_done), .a_prod(s_prod),
    .a_out(s_out), .a_out_valid(s_out_valid), .a_out_ready(s_ready),
    .a_count(s_count), .a_stall(s_stall), .a_sat(s_sat), .a_drop(s_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One low cycle for done, then a rising done with product p; returns
  // 1ns after the edge that samples the term event (done left high).
  task automatic do_term(input logic [31:0] p, input logic rdy);
    @(negedge clk); done = 1'b0;
    @(posedge clk);
    @(negedge clk); done = 1'b1; prod = p; ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic do_sterm(input logic [31:0] p);
    @(negedge clk); s_done = 1'b0;
    @(posedge clk);
    @(negedge clk); s_done = 1'b1; s_prod = p;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({out, out_valid, count, stall, sat, drop} !== 52'd0) begin
      n_err++;
      $display("FAIL reset_state: got out=%0d v=%b cnt=%0d st=%b sat=%b drop=%b, want all 0",
               out, out_valid, count, stall, sat, drop);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [31:0] prods [4];
    logic [7:0]  cnts  [4];
    prods = '{32'd200, -32'sd50, 32'd300, 32'd1000};
    cnts  = '{8'd1, 8'd2, 8'd3, 8'd0};
    for (int i = 0; i < 4; i++) begin
      do_term(prods[i], 1'b1);
      n_vec++;
      if (count !== cnts[i]) begin
        n_err++;
        $display("FAIL basic_count[%0d]: got %0d want %0d", i, count, cnts[i]);
      end
    end
    n_vec++;
    if (out !== 40'sd1450 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL basic_result: got out=%0d v=%b want 1450 v=1", $signed(out), out_valid);
    end
    @(negedge clk); done = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || out !== 40'sd1450) begin
      n_err++;
      $display("FAIL basic_accepted: got out=%0d v=%b want 1450 v=0", $signed(out), out_valid);
    end
  endtask

  task automatic test_level_done;
    @(negedge clk); done = 1'b1; prod = 32'd7;
    @(posedge clk); #1;
    n_vec++;
    if (count !== 8'd1) begin
      n_err++;
      $display("FAIL level_first: got count=%0d want 1", count);
    end
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (count !== 8'd1) begin
      n_err++;
      $display("FAIL level_held: got count=%0d want 1", count);
    end
    for (int i = 0; i < 3; i++) do_term(32'd0, 1'b1);
    n_vec++;
    if (out !== 40'sd7 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL level_result: got out=%0d v=%b want 7 v=1", $signed(out), out_valid);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 4; i++) do_term(32'd1, 1'b0);
    n_vec++;
    if (out !== 40'sd4 || out_valid !== 1'b1 || stall !== 1'b0 || count !== 8'd0) begin
      n_err++;
      $display("FAIL bp_group1: got out=%0d v=%b st=%b cnt=%0d want 4 1 0 0",
               $signed(out), out_valid, stall, count);
    end
    for (int i = 0; i < 4; i++) do_term(32'd1, 1'b0);
    n_vec++;
    if (stall !== 1'b1 || count !== 8'd3 || out_valid !== 1'b1 || drop !== 1'b0) begin
      n_err++;
      $display("FAIL bp_hold: got st=%b cnt=%0d v=%b drop=%b want 1 3 1 0",
               stall, count, out_valid, drop);
    end
    do_term(32'd1, 1'b0);
    n_vec++;
    if (drop !== 1'b1 || stall !== 1'b1 || count !== 8'd3) begin
      n_err++;
      $display("FAIL bp_drop: got drop=%b st=%b cnt=%0d want 1 1 3", drop, stall, count);
    end
    @(negedge clk); done = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    n_vec++;
    if (out !== 40'sd4 || out_valid !== 1'b1 || stall !== 1'b0 || count !== 8'd0) begin
      n_err++;
      $display("FAIL bp_release: got out=%0d v=%b st=%b cnt=%0d want 4 1 0 0",
               $signed(out), out_valid, stall, count);
    end
    @(negedge clk); ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 4; i++) do_term(32'(i), 1'b0);
    n_vec++;
    if (out !== 40'sd10 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: got out=%0d v=%b want 10 v=1", $signed(out), out_valid);
    end
    for (int i = 0; i < 3; i++) do_term(32'd5, 1'b0);
    do_term(32'd5, 1'b1);
    ready = 1'b0;
    n_vec++;
    if (out !== 40'sd20 || out_valid !== 1'b1 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_replace: got out=%0d v=%b st=%b want 20 1 0",
               $signed(out), out_valid, stall);
    end
    @(negedge clk); done = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clear;
    do_term(32'd100, 1'b1);
    do_term(32'd200, 1'b1);
    n_vec++;
    if (count !== 8'd2) begin
      n_err++;
      $display("FAIL clr_pre: got count=%0d want 2", count);
    end
    @(negedge clk); done = 1'b0; clr = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (count !== 8'd0 || drop !== 1'b0 || out !== 40'sd20 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL clr_state: got cnt=%0d drop=%b out=%0d v=%b want 0 0 20 0",
               count, drop, $signed(out), out_valid);
    end
    @(negedge clk); clr = 1'b0;
    for (int i = 1; i <= 4; i++) do_term(32'(i), 1'b1);
    n_vec++;
    if (out !== 40'sd10 || out_valid !== 1'b1 || sat !== 1'b0 || drop !== 1'b0) begin
      n_err++;
      $display("FAIL clr_result: got out=%0d v=%b sat=%b drop=%b want 10 1 0 0",
               $signed(out), out_valid, sat, drop);
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 4; i++) do_term(32'd3, 1'b0);
    do_term(32'd5, 1'b0);
    n_vec++;
    if (out !== 40'sd12 || out_valid !== 1'b1 || count !== 8'd1) begin
      n_err++;
      $display("FAIL arst_pre: got out=%0d v=%b cnt=%0d want 12 1 1",
               $signed(out), out_valid, count);
    end
    @(negedge clk); done = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out, out_valid, count, stall, sat, drop} !== 52'd0) begin
      n_err++;
      $display("FAIL arst_immediate: got out=%0d v=%b cnt=%0d st=%b sat=%b drop=%b want all 0",
               out, out_valid, count, stall, sat, drop);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_saturation;
    for (int k = 1; k <= 8; k++) begin
      do_sterm(32'h7FFF_FFFF);
      n_vec++;
      if (s_sat !== (k >= 5)) begin
        n_err++;
        $display("FAIL sat_pos_flag[%0d]: got %b want %b", k, s_sat, (k >= 5));
      end
    end
    n_vec++;
    if (s_out !== 34'h1_FFFF_FFFF || s_out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL sat_pos_result: got %0d v=%b want 8589934591 v=1", $signed(s_out), s_out_valid);
    end
    @(negedge clk); s_done = 1'b0; s_clr = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); s_clr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      do_sterm(32'h8000_0000);
      n_vec++;
      if (s_sat !== (k >= 5)) begin
        n_err++;
        $display("FAIL sat_neg_flag[%0d]: got %b want %b", k, s_sat, (k >= 5));
      end
    end
    n_vec++;
    if (s_out !== 34'h2_0000_0000 || s_out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL sat_neg_result: got %0d v=%b want -8589934592 v=1", $signed(s_out), s_out_valid);
    end
  endtask

  initial begin
    clr = 1'b0; done = 1'b0; ready = 1'b1; prod = '0;
    s_clr = 1'b0; s_done = 1'b0; s_ready = 1'b1; s_prod = '0;
    rst_n = 1'b1;
    test_reset;
    test_basic;
    test_level_done;
    test_backpressure;
    test_back_to_back;
    test_clear;
    test_async_reset;
    test_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
